// File: rtl/data_mem_sized.sv
// Byte-addressable data memory of 2^DEPTH_LOG2 32-bit words with byte/half/word
// access, sign or zero extended loads, alignment checking and optional zero-fill.
`timescale 1ns/1ps
module data_mem_sized #(
  parameter int DEPTH_LOG2     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic        Ready,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_ONE = 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           high_bits;
  logic                  misaligned;
  logic                  reject;
  logic                  accept;
  logic [31:0]           stored_word;
  logic [31:0]           shifted;
  logic [31:0]           load_value;
  logic [31:0]           write_shifted;
  logic [3:0]            write_mask;

  assign Ready     = (state == IDLE);
  assign accept    = Ready && (MemRead || MemWrite);
  assign word_idx  = Address[DEPTH_LOG2+1:2];
  assign lane      = Address[1:0];
  assign high_bits = Address >> (DEPTH_LOG2 + 2);

  // Reject misaligned, reserved-size and out-of-range accesses.
  always_comb begin
    misaligned = 1'b0;
    case (Size)
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    reject = misaligned || (Size == 2'b11) || (high_bits != 32'h0);
  end

  always_comb begin
    stored_word = mem[word_idx];
    shifted     = stored_word >> {lane, 3'b000};
    case (Size)
      2'b00:   load_value = Unsigned ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_value = Unsigned ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_value = shifted;
    endcase
  end

  always_comb begin
    write_shifted = WriteData << {lane, 3'b000};
    case (Size)
      2'b00:   write_mask = 4'b0001 << lane;
      2'b01:   write_mask = 4'b0011 << lane;
      2'b10:   write_mask = 4'b1111;
      default: write_mask = 4'b0000;
    endcase
  end

  // Storage array: zero-filled one word per cycle in CLEAR, lane writes in IDLE.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= 32'h0;
      end else if (accept && MemWrite && !reject) begin
        for (int b = 0; b < 4; b++) begin
          if (write_mask[b]) mem[word_idx][b*8 +: 8] <= write_shifted[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt   <= '0;
      ReadData  <= 32'h0;
      ReadValid <= 1'b0;
      Error     <= 1'b0;
    end else begin
      ReadValid <= 1'b0;
      Error     <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + CNT_ONE;
          if (&clr_cnt) state <= IDLE;
        end
        IDLE: begin
          // Reads sample the array before this edge's write: read-before-write.
          if (accept) begin
            Error <= reject;
            if (MemRead) begin
              ReadValid <= 1'b1;
              ReadData  <= reject ? 32'h0 : load_value;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed self-checking bench for data_mem_sized: fill timing, lane access,
// extension, error handling, read-before-write and reset during fill.
`timescale 1ns/1ps
module tb_data_mem_sized;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [1:0]  Size = 2'b10;
  logic        Unsigned = 1'b0;
  logic        Ready;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Error;

  int checks = 0;
  int errors = 0;
  int n;

  data_mem_sized #(.DEPTH_LOG2(8), .CLEAR_ON_RESET(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .Size(Size), .Unsigned(Unsigned),
    .Ready(Ready), .ReadData(ReadData), .ReadValid(ReadValid), .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request for a single cycle; outputs are valid on return.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] sz, input logic uns);
    @(negedge Clk);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = wdata;
    Size      = sz;
    Unsigned  = uns;
    @(posedge Clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic waitReady(output int cycles);
    cycles = 0;
    while (!Ready && cycles < 1000) begin
      @(posedge Clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    // Reset and fill timing
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("rst_readdata", ReadData, 32'h0);
    checkOutput("rst_readvalid", {31'h0, ReadValid}, 32'h0);
    checkOutput("rst_error", {31'h0, Error}, 32'h0);
    checkOutput("rst_ready", {31'h0, Ready}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    waitReady(n);
    checkOutput("fill_cycles", 32'(n), 32'd256);

    applyStimulus(1, 0, 32'h3FC, 32'h0, 2'b10, 0);
    checkOutput("rd_3fc_valid", {31'h0, ReadValid}, 32'h1);
    checkOutput("rd_3fc_data", ReadData, 32'h0);

    // Lane access and extension
    applyStimulus(0, 1, 32'h10, 32'h8899AABB, 2'b10, 0);
    checkOutput("wr_10_valid", {31'h0, ReadValid}, 32'h0);
    checkOutput("wr_10_error", {31'h0, Error}, 32'h0);
    applyStimulus(1, 0, 32'h13, 32'h0, 2'b00, 0);
    checkOutput("rdb_13_signed", ReadData, 32'hFFFFFF88);
    applyStimulus(1, 0, 32'h10, 32'h0, 2'b01, 1);
    checkOutput("rdh_10_unsigned", ReadData, 32'h0000AABB);
    applyStimulus(1, 0, 32'h12, 32'h0, 2'b01, 0);
    checkOutput("rdh_12_signed", ReadData, 32'hFFFF8899);
    applyStimulus(1, 0, 32'h11, 32'h0, 2'b00, 1);
    checkOutput("rdb_11_unsigned", ReadData, 32'h000000AA);
    applyStimulus(0, 1, 32'h11, 32'h0000005A, 2'b00, 0);
    applyStimulus(1, 0, 32'h10, 32'h0, 2'b10, 0);
    checkOutput("rdw_10_after_byte", ReadData, 32'h88995ABB);
    applyStimulus(0, 1, 32'h16, 32'h0000C3D4, 2'b01, 0);
    applyStimulus(1, 0, 32'h14, 32'h0, 2'b10, 0);
    checkOutput("rdw_14_after_half", ReadData, 32'hC3D40000);

    // ReadData holds while idle
    @(posedge Clk);
    #1;
    checkOutput("hold_valid", {31'h0, ReadValid}, 32'h0);
    checkOutput("hold_data", ReadData, 32'hC3D40000);

    // Rejected accesses
    applyStimulus(1, 0, 32'h12, 32'h0, 2'b10, 0);
    checkOutput("err_w12_error", {31'h0, Error}, 32'h1);
    checkOutput("err_w12_valid", {31'h0, ReadValid}, 32'h1);
    checkOutput("err_w12_data", ReadData, 32'h0);
    applyStimulus(1, 0, 32'h01, 32'h0, 2'b01, 0);
    checkOutput("err_h01_error", {31'h0, Error}, 32'h1);
    checkOutput("err_h01_data", ReadData, 32'h0);
    applyStimulus(1, 0, 32'h10, 32'h0, 2'b11, 0);
    checkOutput("err_size11_error", {31'h0, Error}, 32'h1);
    checkOutput("err_size11_data", ReadData, 32'h0);
    applyStimulus(1, 0, 32'h400, 32'h0, 2'b10, 0);
    checkOutput("err_400_error", {31'h0, Error}, 32'h1);
    checkOutput("err_400_valid", {31'h0, ReadValid}, 32'h1);
    applyStimulus(0, 1, 32'h12, 32'hDEADBEEF, 2'b10, 0);
    checkOutput("err_wr12_error", {31'h0, Error}, 32'h1);
    checkOutput("err_wr12_valid", {31'h0, ReadValid}, 32'h0);
    applyStimulus(0, 1, 32'h410, 32'hDEADBEEF, 2'b10, 0);
    checkOutput("err_wr410_error", {31'h0, Error}, 32'h1);
    applyStimulus(1, 0, 32'h10, 32'h0, 2'b10, 0);
    checkOutput("mem_unchanged_err", {31'h0, Error}, 32'h0);
    checkOutput("mem_unchanged", ReadData, 32'h88995ABB);

    // Read-before-write, back to back
    applyStimulus(0, 1, 32'h20, 32'hCAFEF00D, 2'b10, 0);
    applyStimulus(1, 1, 32'h20, 32'h12345678, 2'b10, 0);
    checkOutput("rbw_old", ReadData, 32'hCAFEF00D);
    applyStimulus(1, 0, 32'h20, 32'h0, 2'b10, 0);
    checkOutput("rbw_new", ReadData, 32'h12345678);
    checkOutput("rbw_new_valid", {31'h0, ReadValid}, 32'h1);

    // Reset during fill restarts it; requests in fill are ignored
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("rst2_readdata", ReadData, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(1, 0, 32'h3FC, 32'h0, 2'b10, 0);
    checkOutput("fill_rd_ignored", {31'h0, ReadValid}, 32'h0);
    applyStimulus(1, 0, 32'h12, 32'h0, 2'b10, 0);
    checkOutput("fill_err_ignored", {31'h0, Error}, 32'h0);
    repeat (98) @(posedge Clk);
    #1;
    checkOutput("fill_mid_ready", {31'h0, Ready}, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    Reset = 1'b0;
    waitReady(n);
    checkOutput("refill_cycles", 32'(n), 32'd256);
    applyStimulus(1, 0, 32'h20, 32'h0, 2'b10, 0);
    checkOutput("refill_rd_20", ReadData, 32'h0);
    applyStimulus(1, 0, 32'h10, 32'h0, 2'b10, 0);
    checkOutput("refill_rd_10", ReadData, 32'h0);
    checkOutput("refill_rd_10_valid", {31'h0, ReadValid}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
